// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared distance-transform constants, state enum and neighbour offsets (DT_RIDGE_8N_EN selects 8-neighbour set)
package dt_pkg;

  localparam int IMG_W     = 128;
  localparam int PIX_NUM   = IMG_W * IMG_W;
  localparam int WORD_BITS = 16;
  localparam int WORD_NUM  = PIX_NUM / WORD_BITS;
  localparam int PIX_AW    = 14;
  localparam int SKL_AW    = 10;
  localparam int CNT_W     = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_C,
    ST_CMP_C,
    ST_RD_N,
    ST_CMP_N,
    ST_EVAL,
    ST_WR,
    ST_DONE
  } dt_ridge_state_e;

  // Linear address offsets of the eight surrounding pixels
  localparam int OFF_UL = -IMG_W - 1;
  localparam int OFF_U  = -IMG_W;
  localparam int OFF_UR = -IMG_W + 1;
  localparam int OFF_L  = -1;
  localparam int OFF_R  = 1;
  localparam int OFF_DL = IMG_W - 1;
  localparam int OFF_D  = IMG_W;
  localparam int OFF_DR = IMG_W + 1;

`ifdef DT_RIDGE_8N_EN
  localparam int NBR_NUM = 8;

  // Row step of neighbour k: UL, U, UR, L, R, DL, D, DR
  function automatic int nbr_dr(input int k);
    case (k)
      0, 1, 2: nbr_dr = -1;
      5, 6, 7: nbr_dr = 1;
      default: nbr_dr = 0;
    endcase
  endfunction

  // Column step of neighbour k
  function automatic int nbr_dc(input int k);
    case (k)
      0, 3, 5: nbr_dc = -1;
      2, 4, 7: nbr_dc = 1;
      default: nbr_dc = 0;
    endcase
  endfunction
`else
  localparam int NBR_NUM = 4;

  // Row step of neighbour k: U, L, R, D
  function automatic int nbr_dr(input int k);
    case (k)
      0:       nbr_dr = -1;
      3:       nbr_dr = 1;
      default: nbr_dr = 0;
    endcase
  endfunction

  // Column step of neighbour k
  function automatic int nbr_dc(input int k);
    case (k)
      1:       nbr_dc = -1;
      2:       nbr_dc = 1;
      default: nbr_dc = 0;
    endcase
  endfunction
`endif

  function automatic int nbr_off(input int k);
    nbr_off = nbr_dr(k) * IMG_W + nbr_dc(k);
  endfunction

endpackage

// File: rtl/dt_ridge_nbr_gen.sv
// rtl/dt_ridge_nbr_gen.sv - finds the next in-image neighbour at or after an ordinal (set chosen by DT_RIDGE_8N_EN)
module dt_ridge_nbr_gen
  import dt_pkg::*;
(
  input  logic [PIX_AW-1:0] i_pix,
  input  logic [3:0]        i_ord,
  output logic [PIX_AW-1:0] o_addr,
  output logic [3:0]        o_ord,
  output logic              o_in_img,
  output logic              o_last
);

  logic [6:0]         w_row;
  logic [6:0]         w_col;
  logic [NBR_NUM-1:0] w_in_vec;

  assign w_row = i_pix[13:7];
  assign w_col = i_pix[6:0];

  // Flag which neighbours fall inside the image for this pixel
  always_comb begin
    w_in_vec = '0;
    for (int k = 0; k < NBR_NUM; k++) begin
      w_in_vec[k] = !((nbr_dr(k) < 0 && w_row == 7'd0) ||
                      (nbr_dr(k) > 0 && w_row == 7'(IMG_W - 1)) ||
                      (nbr_dc(k) < 0 && w_col == 7'd0) ||
                      (nbr_dc(k) > 0 && w_col == 7'(IMG_W - 1)));
    end
  end

  // Pick the lowest in-image ordinal >= i_ord; out-of-image ones cost no cycles
  always_comb begin
    int v_sel;
    v_sel    = 0;
    o_in_img = 1'b0;
    for (int k = NBR_NUM - 1; k >= 0; k--) begin
      if (k >= int'(i_ord) && w_in_vec[k]) begin
        v_sel    = k;
        o_in_img = 1'b1;
      end
    end
    o_last = 1'b1;
    for (int k = 0; k < NBR_NUM; k++) begin
      if (k > v_sel && w_in_vec[k]) o_last = 1'b0;
    end
    o_ord  = 4'(v_sel);
    o_addr = i_pix + 14'(nbr_off(v_sel));
  end

endmodule

// File: rtl/dt_ridge.sv
// rtl/dt_ridge.sv - ridge detector over the distance map, packs a skeleton bitmap and counts ridge pixels (DT_RIDGE_8N_EN: 8-neighbour test)
module dt_ridge
  import dt_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_res_rd,
  output logic [PIX_AW-1:0] o_res_addr,
  input  logic [7:0]        i_res_di,
  output logic              o_skl_wr,
  output logic [SKL_AW-1:0] o_skl_addr,
  output logic [15:0]       o_skl_do,
  output logic [CNT_W-1:0]  o_ridge_cnt
);

  dt_ridge_state_e   r_state;
  logic [PIX_AW-1:0] r_p;
  logic [7:0]        r_c;
  logic              r_mark;
  logic [3:0]        r_ord;
  logic              r_last;
  logic [15:0]       r_word;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_res_rd;
  logic [PIX_AW-1:0] r_res_addr;
  logic              r_skl_wr;
  logic [SKL_AW-1:0] r_skl_addr;
  logic [15:0]       r_skl_do;

  logic [3:0]        w_gen_ord;
  logic [PIX_AW-1:0] w_nbr_addr;
  logic [3:0]        w_nbr_ord;
  logic              w_nbr_in;
  logic              w_nbr_last;
  logic [15:0]       w_word_next;

  // First neighbour search when the centre arrives, otherwise continue after the current one
  assign w_gen_ord   = (r_state == ST_CMP_C) ? 4'd0 : r_ord + 4'd1;
  assign w_word_next = r_word | (16'(r_mark) << r_p[3:0]);

  dt_ridge_nbr_gen u_nbr_gen (
    .i_pix    (r_p),
    .i_ord    (w_gen_ord),
    .o_addr   (w_nbr_addr),
    .o_ord    (w_nbr_ord),
    .o_in_img (w_nbr_in),
    .o_last   (w_nbr_last)
  );

  // Scan FSM; strobes are registered so they line up with the state they belong to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_p        <= '0;
      r_c        <= '0;
      r_mark     <= 1'b0;
      r_ord      <= '0;
      r_last     <= 1'b0;
      r_word     <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_res_rd   <= 1'b0;
      r_res_addr <= '0;
      r_skl_wr   <= 1'b0;
      r_skl_addr <= '0;
      r_skl_do   <= '0;
    end else begin
      r_done     <= 1'b0;
      r_res_rd   <= 1'b0;
      r_res_addr <= '0;
      r_skl_wr   <= 1'b0;
      r_skl_addr <= '0;
      r_skl_do   <= '0;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_p        <= '0;
            r_cnt      <= '0;
            r_word     <= '0;
            r_busy     <= 1'b1;
            r_res_rd   <= 1'b1;
            r_res_addr <= '0;
            r_state    <= ST_RD_C;
          end
        end
        ST_RD_C: r_state <= ST_CMP_C;
        ST_CMP_C: begin
          r_c <= i_res_di;
          if (i_res_di == 8'd0) begin
            r_mark  <= 1'b0;
            r_state <= ST_EVAL;
          end else if (w_nbr_in) begin
            r_mark     <= 1'b1;
            r_ord      <= w_nbr_ord;
            r_last     <= w_nbr_last;
            r_res_rd   <= 1'b1;
            r_res_addr <= w_nbr_addr;
            r_state    <= ST_RD_N;
          end else begin
            r_mark  <= 1'b1;
            r_state <= ST_EVAL;
          end
        end
        ST_RD_N: r_state <= ST_CMP_N;
        ST_CMP_N: begin
          if (i_res_di > r_c) begin
            r_mark  <= 1'b0;
            r_state <= ST_EVAL;
          end else if (!r_last) begin
            r_ord      <= w_nbr_ord;
            r_last     <= w_nbr_last;
            r_res_rd   <= 1'b1;
            r_res_addr <= w_nbr_addr;
            r_state    <= ST_RD_N;
          end else begin
            r_state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          r_cnt <= r_cnt + CNT_W'(r_mark);
          if (r_p[3:0] == 4'd15) begin
            r_word     <= '0;
            r_skl_wr   <= 1'b1;
            r_skl_addr <= r_p[13:4];
            r_skl_do   <= w_word_next;
            r_state    <= ST_WR;
          end else begin
            r_word     <= w_word_next;
            r_p        <= r_p + 14'd1;
            r_res_rd   <= 1'b1;
            r_res_addr <= r_p + 14'd1;
            r_state    <= ST_RD_C;
          end
        end
        ST_WR: begin
          if (r_p == 14'(PIX_NUM - 1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_p        <= r_p + 14'd1;
            r_res_rd   <= 1'b1;
            r_res_addr <= r_p + 14'd1;
            r_state    <= ST_RD_C;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_res_rd    = r_res_rd;
  assign o_res_addr  = r_res_addr;
  assign o_skl_wr    = r_skl_wr;
  assign o_skl_addr  = r_skl_addr;
  assign o_skl_do    = r_skl_do;
  assign o_ridge_cnt = r_cnt;

endmodule

// File: tb/tb_dt_ridge.sv
// tb/tb_dt_ridge.sv - directed bench for dt_ridge (expectations follow DT_RIDGE_8N_EN)
module tb_dt_ridge;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_start = 1'b0;
  logic [7:0]  i_res_di = 8'd0;
  logic        o_busy, o_done, o_res_rd, o_skl_wr;
  logic [13:0] o_res_addr;
  logic [9:0]  o_skl_addr;
  logic [15:0] o_skl_do;
  logic [14:0] o_ridge_cnt;

  logic [7:0]  mem [16384];
  logic [15:0] skl [1024];
  logic [15:0] exp_skl [1024];
  int          exp_q[$];
  int          nbr_dr [8];
  int          nbr_dc [8];
  int          nn;
  int          rd_idx, rd_err, wr_idx, wr_err, idle_err;
  bit          mon_en = 1'b0;
  int          cyc, last_wr_cyc;
  int          checks = 0;
  int          errors = 0;
  int          exp_done_cyc, exp_cnt, bad_words;
  bit          found;

  always #5 clk = ~clk;

  dt_ridge dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_res_rd    (o_res_rd),
    .o_res_addr  (o_res_addr),
    .i_res_di    (i_res_di),
    .o_skl_wr    (o_skl_wr),
    .o_skl_addr  (o_skl_addr),
    .o_skl_do    (o_skl_do),
    .o_ridge_cnt (o_ridge_cnt)
  );

  // Result RAM: one-cycle read latency
  always @(posedge clk) if (o_res_rd) i_res_di <= mem[o_res_addr];

  // Capture writes and compare the read stream with the expected trace
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_res_rd) begin
        if (rd_idx >= exp_q.size() || exp_q[rd_idx] != int'(o_res_addr)) rd_err++;
        rd_idx++;
      end else if (o_res_addr != 14'd0) idle_err++;
      if (o_skl_wr) begin
        if (o_skl_addr != 10'(wr_idx)) wr_err++;
        skl[o_skl_addr] = o_skl_do;
        wr_idx++;
        last_wr_cyc = cyc;
      end else if (o_skl_addr != 10'd0 || o_skl_do != 16'd0) idle_err++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected read addresses: centre, then in-image neighbours until one is larger
  task automatic build_trace();
    exp_q.delete();
    for (int p = 0; p < 16384; p++) begin
      int r, c;
      r = p / 128;
      c = p % 128;
      exp_q.push_back(p);
      if (mem[p] != 8'd0) begin
        for (int k = 0; k < nn; k++) begin
          int nr, nc;
          nr = r + nbr_dr[k];
          nc = c + nbr_dc[k];
          if (nr >= 0 && nr < 128 && nc >= 0 && nc < 128) begin
            exp_q.push_back(nr * 128 + nc);
            if (mem[nr * 128 + nc] > mem[p]) break;
          end
        end
      end
    end
  endtask

  task automatic clear_capture();
    for (int i = 0; i < 1024; i++) begin
      skl[i] = 16'd0;
      exp_skl[i] = 16'd0;
    end
    rd_idx = 0; rd_err = 0; wr_idx = 0; wr_err = 0; idle_err = 0; last_wr_cyc = 0;
  endtask

  task automatic start_scan();
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    cyc = 1;
  endtask

  initial begin
`ifdef DT_RIDGE_8N_EN
    nn = 8;
    nbr_dr = '{-1, -1, -1, 0, 0, 1, 1, 1};
    nbr_dc = '{-1, 0, 1, -1, 1, -1, 0, 1};
`else
    nn = 4;
    nbr_dr = '{-1, 0, 0, 1, 0, 0, 0, 0};
    nbr_dc = '{0, -1, 1, 0, 0, 0, 0, 0};
`endif
    for (int i = 0; i < 16384; i++) mem[i] = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_done", {o_busy, o_done}, 2'b00);
    chk("rst_res", {o_res_rd, o_res_addr}, 15'd0);
    chk("rst_skl", {o_skl_wr, o_skl_addr, o_skl_do}, 27'd0);
    chk("rst_cnt", o_ridge_cnt, 15'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // All-zero map: cadence check, then reset while word 300 is written
    build_trace();
    clear_capture();
    mon_en = 1'b1;
    start_scan();
    chk("first_rd_c", {o_busy, o_res_rd, o_res_addr}, {1'b1, 1'b1, 14'd0});
    found = 1'b0;
    while (!found && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (o_skl_wr && o_skl_addr == 10'd300) found = 1'b1;
    end
    chk("wr300_seen", found, 1);
    chk("wr300_cycle", cyc, 14749);
    chk("wr300_data", o_skl_do, 16'h0000);
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_outs", {o_busy, o_done, o_res_rd, o_res_addr, o_skl_wr, o_skl_addr, o_skl_do},
        44'd0);
    chk("midrst_cnt", o_ridge_cnt, 15'd0);
    chk("zero_writes", wr_idx, 300);
    chk("zero_wr_order", wr_err, 0);
    chk("zero_rd_trace", rd_err, 0);
    chk("zero_idle", idle_err, 0);
    bad_words = 0;
    for (int i = 0; i < 1024; i++) if (skl[i] != 16'd0) bad_words++;
    chk("zero_words", bad_words, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // Combined map: isolated pixel, plateau, corner pair, diagonal pair
    mem[0] = 8'd3;
    mem[1] = 8'd4;
    mem[645] = 8'd1;
    for (int r = 10; r <= 12; r++)
      for (int c = 20; c <= 22; c++) mem[r * 128 + c] = 8'd2;
    mem[2580] = 8'd2;
    mem[2709] = 8'd3;
    build_trace();
    clear_capture();
    exp_skl[0] = 16'h0002;
    exp_skl[40] = 16'h0020;
    exp_skl[81] = 16'h0070;
    exp_skl[89] = 16'h0070;
    exp_skl[97] = 16'h0070;
    exp_skl[169] = 16'h0020;
`ifdef DT_RIDGE_8N_EN
    exp_done_cyc = 50381;
    exp_cnt = 12;
`else
    exp_skl[161] = 16'h0010;
    exp_done_cyc = 50281;
    exp_cnt = 13;
`endif
    mon_en = 1'b1;
    start_scan();
    chk("scan_busy", o_busy, 1);
    while (!o_done && cyc < 60000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 200) i_start = 1'b1;
      if (cyc == 201) i_start = 1'b0;
    end
    chk("done_seen", o_done, 1);
    chk("done_cycle", cyc, exp_done_cyc);
    chk("last_wr_cycle", last_wr_cyc, exp_done_cyc - 1);
    chk("busy_at_done", o_busy, 0);
    chk("ridge_cnt", o_ridge_cnt, exp_cnt);
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    chk("start_at_done_ign", {o_busy, o_res_rd, o_done}, 3'b000);
    repeat (5) @(posedge clk);
    #1;
    chk("cnt_held", o_ridge_cnt, exp_cnt);
    chk("idle_after", {o_busy, o_res_rd}, 2'b00);
    mon_en = 1'b0;
    chk("map_writes", wr_idx, 1024);
    chk("map_wr_order", wr_err, 0);
    chk("map_rd_count", rd_idx, exp_q.size());
    chk("map_rd_trace", rd_err, 0);
    chk("map_idle", idle_err, 0);
    chk("word0", skl[0], exp_skl[0]);
    chk("word40", skl[40], 16'h0020);
    chk("word89", skl[89], 16'h0070);
    chk("word161", skl[161], exp_skl[161]);
    chk("word169", skl[169], 16'h0020);
    bad_words = 0;
    for (int i = 0; i < 1024; i++) if (skl[i] != exp_skl[i]) bad_words++;
    chk("map_words", bad_words, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
